// File: rtl/riscv_pmpchk_arb.sv
// riscv_pmpchk_arb: shares one PMP checker between the instruction-fetch (IF) and
// data-memory (DM) requesters.
//   Per requester (if_*/dm_*): req/adr/size(/we) in, gnt pulse out,
//     rsp_valid/rsp_exc out, rsp_ready in.
//   Checker side (chk_*): instr/adr/size/we/stall out, exc in.
// The request payload is latched at grant and held from CHECK through RESP, so the
// checker sees stable inputs for both of its pipeline cycles.

package riscv_pmpchk_arb_pkg;
    typedef logic [2:0] biu_size_t;
    localparam biu_size_t WORD = 3'd2;
endpackage

module riscv_pmpchk_arb
    import riscv_pmpchk_arb_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned PLEN         = (XLEN == 32) ? 34 : 56,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            if_req_i,
    input  logic [PLEN-1:0] if_adr_i,
    input  biu_size_t       if_size_i,
    output logic            if_gnt_o,
    output logic            if_rsp_valid_o,
    output logic            if_rsp_exc_o,
    input  logic            if_rsp_ready_i,

    input  logic            dm_req_i,
    input  logic [PLEN-1:0] dm_adr_i,
    input  biu_size_t       dm_size_i,
    input  logic            dm_we_i,
    output logic            dm_gnt_o,
    output logic            dm_rsp_valid_o,
    output logic            dm_rsp_exc_o,
    input  logic            dm_rsp_ready_i,

    output logic            chk_instr_o,
    output logic [PLEN-1:0] chk_adr_o,
    output biu_size_t       chk_size_o,
    output logic            chk_we_o,
    output logic            chk_stall_o,
    input  logic            chk_exc_i
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t          state_q;
    logic            owner_if_q;
    logic            if_rsp_valid_q;
    logic            dm_rsp_valid_q;
    logic            chk_instr_q;
    logic [PLEN-1:0] chk_adr_q;
    biu_size_t       chk_size_q;
    logic            chk_we_q;
    logic            chk_stall_q;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;

    logic owner_rdy;
    logic arb_en;
    logic starved;
    logic if_win;
    logic dm_win;

    // Arbitration: open in IDLE or on the owner's response-accept cycle.
    always_comb begin
        owner_rdy = owner_if_q ? if_rsp_ready_i : dm_rsp_ready_i;
        arb_en    = (state_q == IDLE) || ((state_q == RESP) && owner_rdy);
        starved   = (starve_q == SW'(STARVE_LIMIT));
        if_win    = arb_en && if_req_i && (!dm_req_i || starved);
        dm_win    = arb_en && dm_req_i && !if_win;

        // Count data grants that overtake a waiting instruction request.
        starve_d = starve_q;
        if (if_win) begin
            starve_d = '0;
        end else if (dm_win) begin
            if (!if_req_i)    starve_d = '0;
            else if (!starved) starve_d = starve_q + SW'(1);
        end
    end

    // State, latched checker payload and registered response flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            owner_if_q     <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            chk_instr_q    <= 1'b0;
            chk_adr_q      <= '0;
            chk_size_q     <= WORD;
            chk_we_q       <= 1'b0;
            chk_stall_q    <= 1'b1;
            starve_q       <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE, RESP: begin
                    if (if_win || dm_win) begin
                        state_q        <= CHECK;
                        owner_if_q     <= if_win;
                        chk_instr_q    <= if_win;
                        chk_adr_q      <= if_win ? if_adr_i : dm_adr_i;
                        chk_size_q     <= if_win ? if_size_i : dm_size_i;
                        chk_we_q       <= if_win ? 1'b0 : dm_we_i;
                        chk_stall_q    <= 1'b0;
                        if_rsp_valid_q <= 1'b0;
                        dm_rsp_valid_q <= 1'b0;
                    end else if ((state_q == RESP) && owner_rdy) begin
                        state_q        <= IDLE;
                        if_rsp_valid_q <= 1'b0;
                        dm_rsp_valid_q <= 1'b0;
                    end
                end
                CHECK: begin
                    // Checker has registered its match state; result is valid next cycle.
                    state_q        <= RESP;
                    chk_stall_q    <= 1'b1;
                    if_rsp_valid_q <= owner_if_q;
                    dm_rsp_valid_q <= !owner_if_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt_o       = if_win;
    assign dm_gnt_o       = dm_win;
    assign if_rsp_valid_o = if_rsp_valid_q;
    assign dm_rsp_valid_o = dm_rsp_valid_q;
    // Exception is passed straight through from the checker to the owner only.
    assign if_rsp_exc_o   = if_rsp_valid_q & chk_exc_i;
    assign dm_rsp_exc_o   = dm_rsp_valid_q & chk_exc_i;
    assign chk_instr_o    = chk_instr_q;
    assign chk_adr_o      = chk_adr_q;
    assign chk_size_o     = chk_size_q;
    assign chk_we_o       = chk_we_q;
    assign chk_stall_o    = chk_stall_q;

endmodule
